// File: rtl/uart_imem_loader.sv
// Serial program loader: receives 8N1 frames of 0x55 | N | 4*N data bytes | CS and writes
// big-endian 32-bit words to instruction memory while holding the CPU.
module uart_imem_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
  input  logic              Clk,
  input  logic              rstn,
  input  logic              uart_rx,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_ok,
  output logic              load_err,
  output logic [2:0]        dbg_state
);

  localparam int unsigned          BIT_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned          TO_W      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]      TO_LIMIT  = TO_W'(TIMEOUT_CLKS);
  localparam logic [7:0]           SYNC_BYTE = 8'h55;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_OK    = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  rx_state_t            rx_state;
  rx_state_t            rx_state_n;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           rx_shift;
  logic [7:0]           rx_byte;
  logic                 bit_hit;
  logic                 half_hit;
  logic                 byte_valid;
  logic                 frame_err;

  assign bit_hit  = (bit_cnt == BIT_LAST);
  assign half_hit = (bit_cnt == HALF_LAST);
  assign rx_byte  = rx_shift;

  // Synchroniser flops reset to the idle line level so reset release cannot fake a start edge.
  always_ff @(posedge Clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_n = RX_START;
      RX_START: if (half_hit) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && bit_idx == 3'd7) rx_state_n = RX_STOP;
      RX_STOP:  if (bit_hit) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!rstn) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      // Bit timer restarts on every state change and every bit centre.
      if (rx_state == RX_IDLE || rx_state_n != rx_state || bit_hit) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
      if (rx_state == RX_START) begin
        bit_idx <= '0;
      end
      if (rx_state == RX_DATA && bit_hit) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && bit_hit) begin
        byte_valid <= rx_sync;
        frame_err  <= !rx_sync;
      end
    end
  end

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] n_words;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_idx;
  logic [23:0]       word;
  logic [7:0]        sum;
  logic [TO_W-1:0]   idle_cnt;
  logic              abort;
  logic              last_word;
  logic              we_n;

  assign abort     = frame_err || (idle_cnt == TO_LIMIT);
  // N == 0 wraps to all-ones, so a full-memory load ends at the top address.
  assign last_word = (addr == n_words - ADDR_W'(1));
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (byte_valid && rx_byte == SYNC_BYTE) state_n = S_COUNT;
      end
      S_COUNT: begin
        if (abort)           state_n = S_ERR;
        else if (byte_valid) state_n = S_DATA;
      end
      S_DATA: begin
        if (abort) begin
          state_n = S_ERR;
        end else if (byte_valid && byte_idx == 2'd3) begin
          we_n = 1'b1;
          if (last_word) state_n = S_CSUM;
        end
      end
      S_CSUM: begin
        if (abort)           state_n = S_ERR;
        else if (byte_valid) state_n = (rx_byte == sum) ? S_OK : S_ERR;
      end
      S_OK:    state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_hold <= 1'b0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
      n_words  <= '0;
      addr     <= '0;
      byte_idx <= '0;
      word     <= '0;
      sum      <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      im_we    <= we_n;
      cpu_hold <= (state_n != S_IDLE);
      load_ok  <= (state == S_OK);
      load_err <= (state == S_ERR);
      if (state inside {S_COUNT, S_DATA, S_CSUM} && !byte_valid) begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end else begin
        idle_cnt <= '0;
      end
      if (state == S_COUNT && byte_valid && !abort) begin
        n_words  <= ADDR_W'(rx_byte);
        sum      <= rx_byte;
        addr     <= '0;
        byte_idx <= '0;
      end
      if (state == S_DATA && byte_valid && !abort) begin
        word     <= {word[15:0], rx_byte};
        sum      <= sum + rx_byte;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) addr <= addr + ADDR_W'(1);
      end
      if (we_n) begin
        im_addr  <= addr;
        im_wdata <= {word, rx_byte};
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: directed frames on a CLKS_PER_BIT=8 instance plus a
// full 256-word load on a faster second instance.
module tb_uart_imem_loader;

  localparam int unsigned CPB      = 8;
  localparam int unsigned CPB_FAST = 4;
  localparam int unsigned TO       = 2000;
  localparam int unsigned AW       = 8;
  localparam int          RES_OK   = 1;
  localparam int          RES_ERR  = 2;

  logic          Clk = 1'b0;
  logic          rstn = 1'b0;
  logic          uart_rx = 1'b1;
  logic          uart_rx_fast = 1'b1;
  logic          im_we, cpu_hold, load_ok, load_err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [2:0]    dbg_state;
  logic          f_im_we, f_cpu_hold, f_load_ok, f_load_err;
  logic [AW-1:0] f_im_addr;
  logic [31:0]   f_im_wdata;
  logic [2:0]    f_dbg_state;

  always #5 Clk = ~Clk;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CLKS(TO)) dut (
    .Clk(Clk), .rstn(rstn), .uart_rx(uart_rx), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_hold(cpu_hold), .load_ok(load_ok), .load_err(load_err),
    .dbg_state(dbg_state)
  );

  uart_imem_loader #(.CLKS_PER_BIT(CPB_FAST), .ADDR_W(AW), .TIMEOUT_CLKS(TO)) dut_fast (
    .Clk(Clk), .rstn(rstn), .uart_rx(uart_rx_fast), .im_we(f_im_we), .im_addr(f_im_addr),
    .im_wdata(f_im_wdata), .cpu_hold(f_cpu_hold), .load_ok(f_load_ok), .load_err(f_load_err),
    .dbg_state(f_dbg_state)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        exp_wr[$];
  wr_t        exp_fast_wr[$];
  int         exp_res[$];
  int         exp_fast_res[$];
  logic [7:0] frame_q[$];
  logic [7:0] cs_acc;
  logic       prev_hold [2];
  int         fast_writes = 0;
  logic [AW-1:0] fast_last_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pending(input int sel);
    if (sel == 0) return exp_wr.size() + exp_res.size();
    return exp_fast_wr.size() + exp_fast_res.size();
  endfunction

  task automatic observe(input int sel, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] data, input logic hold, input logic ok,
                         input logic err);
    wr_t   w;
    int    r;
    int    n;
    string tag;
    tag = (sel == 0) ? "main" : "fast";
    if (we) begin
      n = (sel == 0) ? exp_wr.size() : exp_fast_wr.size();
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_write: addr %0d data 0x%08h, none expected", tag, addr, data);
      end else begin
        if (sel == 0) w = exp_wr.pop_front();
        else          w = exp_fast_wr.pop_front();
        check({tag, "_wr_addr"}, addr, w.addr);
        check({tag, "_wr_data"}, data, w.data);
        check({tag, "_hold_at_write"}, hold, 1);
      end
      if (sel == 1) begin
        fast_writes++;
        fast_last_addr = addr;
      end
    end
    if (ok || err) begin
      n = (sel == 0) ? exp_res.size() : exp_fast_res.size();
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_result: ok %0b err %0b, none expected", tag, ok, err);
      end else begin
        if (sel == 0) r = exp_res.pop_front();
        else          r = exp_fast_res.pop_front();
        check({tag, "_result_ok_err"}, {ok, err}, (r == RES_OK) ? 2'b10 : 2'b01);
        check({tag, "_hold_drop_with_result"}, hold, 0);
        check({tag, "_hold_before_result"}, prev_hold[sel], 1);
      end
    end
    prev_hold[sel] = hold;
  endtask

  always @(negedge Clk) observe(0, im_we, im_addr, im_wdata, cpu_hold, load_ok, load_err);
  always @(negedge Clk) observe(1, f_im_we, f_im_addr, f_im_wdata, f_cpu_hold, f_load_ok, f_load_err);

  task automatic drive(input int sel, input logic v);
    if (sel == 0) uart_rx = v;
    else          uart_rx_fast = v;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
    int unsigned cpb;
    cpb = (sel == 0) ? CPB : CPB_FAST;
    drive(sel, 1'b0);
    repeat (cpb) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      repeat (cpb) @(negedge Clk);
    end
    drive(sel, stop);
    repeat (cpb) @(negedge Clk);
    drive(sel, 1'b1);
    repeat (2) @(negedge Clk);
  endtask

  task automatic begin_frame(input logic [7:0] n);
    frame_q.delete();
    frame_q.push_back(8'h55);
    frame_q.push_back(n);
    cs_acc = n;
  endtask

  task automatic add_byte(input logic [7:0] b);
    frame_q.push_back(b);
    cs_acc = cs_acc + b;
  endtask

  task automatic add_word(input int sel, input logic [31:0] w, input logic [AW-1:0] a,
                          input logic expect_write);
    wr_t e;
    add_byte(w[31:24]);
    add_byte(w[23:16]);
    add_byte(w[15:8]);
    add_byte(w[7:0]);
    e.addr = a;
    e.data = w;
    if (expect_write) begin
      if (sel == 0) exp_wr.push_back(e);
      else          exp_fast_wr.push_back(e);
    end
  endtask

  task automatic end_frame(input logic [7:0] delta);
    frame_q.push_back(cs_acc + delta);
  endtask

  task automatic send_frame(input int sel, input int bad_idx, input int count);
    int n;
    n = (count < 0) ? frame_q.size() : count;
    for (int i = 0; i < n; i++) begin
      send_byte(sel, frame_q[i], i != bad_idx);
      if (sel == 0 && i == 0) begin
        check("hold_after_sync", cpu_hold, 1);
        check("state_count_after_sync", dbg_state, 1);
      end
      if (sel == 0 && i == 1 && i != bad_idx) check("state_data_after_count", dbg_state, 2);
    end
  endtask

  task automatic wait_done(input int sel, input int budget);
    int n;
    n = 0;
    while (pending(sel) != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check((sel == 0) ? "main_events_drained" : "fast_events_drained", pending(sel), 0);
    repeat (6) @(negedge Clk);
  endtask

  initial begin
    logic [7:0] kb;
    prev_hold[0] = 1'b0;
    prev_hold[1] = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_im_we", im_we, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_im_wdata", im_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_load_ok", load_ok, 0);
    check("rst_load_err", load_err, 0);
    check("rst_dbg_state", dbg_state, 0);
    rstn = 1'b1;
    repeat (4) @(negedge Clk);

    // two-word frame, good checksum
    begin_frame(8'd2);
    add_word(0, 32'h1122_3344, 8'd0, 1'b1);
    add_word(0, 32'hAABB_CCDD, 8'd1, 1'b1);
    end_frame(8'd0);
    exp_res.push_back(RES_OK);
    send_frame(0, -1, -1);
    wait_done(0, 100);
    check("t1_hold_released", cpu_hold, 0);

    // same frame, checksum off by one
    begin_frame(8'd2);
    add_word(0, 32'h1122_3344, 8'd0, 1'b1);
    add_word(0, 32'hAABB_CCDD, 8'd1, 1'b1);
    end_frame(8'd1);
    exp_res.push_back(RES_ERR);
    send_frame(0, -1, -1);
    wait_done(0, 100);
    check("t2_hold_released", cpu_hold, 0);

    // junk before a one-word frame
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'hFF, 1'b1);
    send_byte(0, 8'h12, 1'b1);
    check("t3_junk_keeps_idle", dbg_state, 0);
    begin_frame(8'd1);
    add_word(0, 32'hDEAD_BEEF, 8'd0, 1'b1);
    end_frame(8'd0);
    exp_res.push_back(RES_OK);
    send_frame(0, -1, -1);
    wait_done(0, 100);

    // framing error on the third data byte
    begin_frame(8'd2);
    add_word(0, 32'h1122_3344, 8'd0, 1'b0);
    add_word(0, 32'hAABB_CCDD, 8'd1, 1'b0);
    end_frame(8'd0);
    exp_res.push_back(RES_ERR);
    send_frame(0, 4, 5);
    wait_done(0, 100);
    check("t4_state_idle", dbg_state, 0);

    // line goes quiet after five data bytes
    begin_frame(8'd3);
    add_word(0, 32'h0102_0304, 8'd0, 1'b1);
    add_byte(8'h55);
    exp_res.push_back(RES_ERR);
    send_frame(0, -1, -1);
    wait_done(0, TO + 300);
    check("t5_hold_released", cpu_hold, 0);
    check("t5_state_idle", dbg_state, 0);

    // reset mid-DATA
    begin_frame(8'd2);
    add_word(0, 32'h5566_7788, 8'd0, 1'b0);
    add_word(0, 32'h99AA_BBCC, 8'd1, 1'b0);
    end_frame(8'd0);
    send_frame(0, -1, 4);
    check("t6_pre_reset_hold", cpu_hold, 1);
    rstn = 1'b0;
    @(negedge Clk);
    check("t6_rst_im_we", im_we, 0);
    check("t6_rst_im_addr", im_addr, 0);
    check("t6_rst_im_wdata", im_wdata, 0);
    check("t6_rst_cpu_hold", cpu_hold, 0);
    check("t6_rst_load_ok", load_ok, 0);
    check("t6_rst_load_err", load_err, 0);
    check("t6_rst_dbg_state", dbg_state, 0);
    rstn = 1'b1;
    repeat (100) @(negedge Clk);
    begin_frame(8'd2);
    add_word(0, 32'hCAFE_0001, 8'd0, 1'b1);
    add_word(0, 32'hCAFE_0002, 8'd1, 1'b1);
    end_frame(8'd0);
    exp_res.push_back(RES_OK);
    send_frame(0, -1, -1);
    wait_done(0, 100);

    // short low glitch on the idle line, then a real frame shortly after
    uart_rx = 1'b0;
    repeat (2) @(negedge Clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge Clk);
    check("glitch_state_idle", dbg_state, 0);
    begin_frame(8'd1);
    add_word(0, 32'h0BAD_F00D, 8'd0, 1'b1);
    end_frame(8'd0);
    exp_res.push_back(RES_OK);
    send_frame(0, -1, -1);
    wait_done(0, 100);

    // N = 0: full 256-word load on the fast instance
    check("fast_idle_before_load", f_dbg_state, 0);
    begin_frame(8'd0);
    for (int unsigned k = 0; k < 256; k++) begin
      kb = 8'(k);
      add_word(1, {kb, ~kb, kb ^ 8'hA5, 8'h3C}, kb, 1'b1);
    end
    end_frame(8'd0);
    exp_fast_res.push_back(RES_OK);
    send_frame(1, -1, -1);
    wait_done(1, 100);
    check("fast_write_count", fast_writes, 256);
    check("fast_last_addr", fast_last_addr, 255);
    check("fast_hold_released", f_cpu_hold, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
